// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - F/D stall, E bubble and MDU busy control for the five-stage pipeline.
// Optional stall statistics counter built only when STALL_STAT_EN is defined.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        D_md,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        stall,
    output logic        F_WE,
    output logic        D_WE,
    output logic        E_Flush,
    output logic        M_WE,
    output logic        W_WE,
    output logic        M_Flush,
    output logic        W_Flush,
    output logic        md_busy
`ifdef STALL_STAT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [3:0] LP_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV  = 4'(DIV_CYCLES);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_rs_stall;
    logic       w_rt_stall;
    logic       w_data_stall;
    logic       w_md_stall;
    logic       w_stall;

    // Tuse of 3 marks an operand the D instruction never reads; $0 is never a real dependence.
    assign w_rs_stall = (D_rs != 5'd0) && (D_Tuse_rs != 2'd3) &&
                        (((D_rs == E_A3) && (D_Tuse_rs < E_Tnew)) ||
                         ((D_rs == M_A3) && (D_Tuse_rs < M_Tnew)));
    assign w_rt_stall = (D_rt != 5'd0) && (D_Tuse_rt != 2'd3) &&
                        (((D_rt == E_A3) && (D_Tuse_rt < E_Tnew)) ||
                         ((D_rt == M_A3) && (D_Tuse_rt < M_Tnew)));
    assign w_data_stall = w_rs_stall | w_rt_stall;

    always_comb begin
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        if (E_start) begin
            w_cnt_next = E_is_div ? LP_DIV : LP_MULT;
        end else if (r_state == ST_BUSY) begin
            w_cnt_next = r_cnt - 4'd1;
        end
        w_state_next = (w_cnt_next != 4'd0) ? ST_BUSY : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_state <= ST_IDLE;
        end else begin
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
        end
    end

    assign md_busy    = (r_state == ST_BUSY);
    // An issuing mult/div in E already blocks the MDU instruction behind it.
    assign w_md_stall = D_md & (md_busy | E_start);
    assign w_stall    = ~reset & (w_data_stall | w_md_stall);

    assign stall   = w_stall;
    assign F_WE    = ~w_stall;
    assign D_WE    = ~w_stall;
    assign E_Flush = w_stall;
    assign M_WE    = 1'b1;
    assign W_WE    = 1'b1;
    assign M_Flush = 1'b0;
    assign W_Flush = 1'b0;

`ifdef STALL_STAT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - randomized and directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_A3, M_A3;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        D_md, E_start, E_is_div;
    logic        stall, F_WE, D_WE, E_Flush, M_WE, W_WE, M_Flush, W_Flush, md_busy;
`ifdef STALL_STAT_EN
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int       m_cyc   = 0;
    int       m_issue = -1000;
    int       m_n     = 0;
    longint   m_scnt  = 0;

    hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
        .D_md(D_md), .E_start(E_start), .E_is_div(E_is_div),
        .stall(stall), .F_WE(F_WE), .D_WE(D_WE), .E_Flush(E_Flush),
        .M_WE(M_WE), .W_WE(W_WE), .M_Flush(M_Flush), .W_Flush(W_Flush),
        .md_busy(md_busy)
`ifdef STALL_STAT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, m_cyc);
        end
    endtask

    // An operand depends on a producer when it is read, is not $0, names that producer's
    // destination, and is needed before the producer's result exists.
    function automatic bit operand_waits(input int r, input int tuse);
        if (tuse == 3 || r == 0) return 1'b0;
        if (r == int'(E_A3) && tuse < int'(E_Tnew)) return 1'b1;
        if (r == int'(M_A3) && tuse < int'(M_Tnew)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_busy();
        int age;
        age = m_cyc - m_issue;
        return (age >= 1) && (age <= m_n);
    endfunction

    function automatic bit model_stall();
        bit data_w, md_w;
        if (reset) return 1'b0;
        data_w = operand_waits(int'(D_rs), int'(D_Tuse_rs)) || operand_waits(int'(D_rt), int'(D_Tuse_rt));
        md_w   = D_md && (model_busy() || E_start);
        return data_w || md_w;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit s;
            s = model_stall();
            check("stall", longint'(stall), longint'(s));
            check("F_WE", longint'(F_WE), longint'(!s));
            check("D_WE", longint'(D_WE), longint'(!s));
            check("E_Flush", longint'(E_Flush), longint'(s));
            check("md_busy", longint'(md_busy), longint'(model_busy()));
            check("consts", longint'({M_WE, W_WE, M_Flush, W_Flush}), 64'd12);
`ifdef STALL_STAT_EN
            check("stall_cnt", longint'(stall_cnt), m_scnt);
`endif
        end
    end

    always @(posedge clk) begin
        bit s;
        s = model_stall();
        if (reset) begin
            m_issue = -1000;
            m_scnt  = 0;
        end else begin
            if (s && m_scnt != 64'hFFFF_FFFF) m_scnt++;
            if (E_start) begin
                m_issue = m_cyc;
                m_n     = E_is_div ? DIV_N : MULT_N;
            end
        end
        m_cyc++;
    end

    task automatic set_in(input logic [4:0] rs, input logic [1:0] tur, input logic [4:0] rt,
                          input logic [1:0] tut, input logic [4:0] ea3, input logic [1:0] etn,
                          input logic [4:0] ma3, input logic [1:0] mtn,
                          input logic md, input logic st, input logic dv, input logic rst);
        D_rs = rs; D_Tuse_rs = tur; D_rt = rt; D_Tuse_rt = tut;
        E_A3 = ea3; E_Tnew = etn; M_A3 = ma3; M_Tnew = mtn;
        D_md = md; E_start = st; E_is_div = dv; reset = rst;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in(input logic md, input logic rst);
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, md, 1'b0, 1'b0, rst);
    endtask

    initial begin
        idle_in(1'b0, 1'b1);
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        idle_in(1'b0, 1'b0);
        #2;
        check("reset_md_busy", longint'(md_busy), 0);
        check("reset_stall", longint'(stall), 0);

        // Load-use on rs
        set_in(5'd8, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("loaduse_stall", longint'(stall), 1);
        check("loaduse_we", longint'({F_WE, D_WE, E_Flush}), 1);
        E_Tnew = 2'd1;
        #1;
        check("loaduse_ready", longint'(stall), 0);
        next_cycle();
        set_in(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("zero_reg", longint'(stall), 0);
        set_in(5'd0, 2'd3, 5'd9, 2'd3, 5'd9, 2'd2, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rt_unused", longint'(stall), 0);
        D_Tuse_rt = 2'd0;
        #1;
        check("rt_used", longint'(stall), 1);

        // Mult issue with an MDU instruction held in D
        next_cycle();
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                next_cycle();
                E_start = 1'b0;
            end
            #2;
            check("mult_stall", longint'(stall), (c <= 5) ? 1 : 0);
            check("mult_busy", longint'(md_busy), (c >= 1 && c <= 5) ? 1 : 0);
        end

        // Div with a non-MDU instruction in D
        next_cycle();
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        begin
            int busy_cycles;
            busy_cycles = 0;
            for (int c = 0; c <= 12; c++) begin
                if (c > 0) begin
                    next_cycle();
                    E_start = 1'b0;
                end
                #2;
                check("div_nostall", longint'(stall), 0);
                busy_cycles += int'(md_busy);
            end
            check("div_busy_len", busy_cycles, 10);
        end

        // Reset during a div
        next_cycle();
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            E_start = 1'b0;
            reset   = (c == 4);
            #2;
            if (c == 3) check("rst_div_busy_before", longint'(md_busy), 1);
            if (c == 4) check("rst_div_stall_in_reset", longint'(stall), 0);
            if (c == 5) begin
                check("rst_div_busy_after", longint'(md_busy), 0);
                check("rst_div_md_go", longint'(stall), 0);
            end
        end

`ifdef STALL_STAT_EN
        next_cycle();
        idle_in(1'b0, 1'b1);
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            set_in(5'd8, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        next_cycle();
        idle_in(1'b0, 1'b0);
        #2;
        check("stat_seven", longint'(stall_cnt), 7);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        check("stat_cleared", longint'(stall_cnt), 0);
`endif

        // Randomized traffic on a small register set so dependences are frequent
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            set_in(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        next_cycle();
        idle_in(1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall/flush controller for the five-stage CPU. It decides each cycle whether the F/D stages freeze and a bubble enters E, and drives the `WE`/`Flush` controls of the stage registers (`W_reg` and its siblings). Two stall sources are combined:

- a Tuse/Tnew register-dependence check between D and the E/M producers;
- a multi-cycle MDU busy scheduler that holds MDU-class instructions in D while a mult/div is in flight.

## Interface

Parameters:

- `MULT_CYCLES`, 5 — busy cycles after a mult/multu issue (1..15).
- `DIV_CYCLES`, 10 — busy cycles after a div/divu issue (1..15).

Ports:

- `clk` in 1 — clock; all state updates on the rising edge.
- `reset` in 1 — reset, synchronous, active-high.
- `D_rs` in 5 — rs field of the D-stage instruction.
- `D_rt` in 5 — rt field of the D-stage instruction.
- `D_Tuse_rs` in 2 — cycles until D needs rs (0..2); 3 means rs is not read.
- `D_Tuse_rt` in 2 — same encoding, for rt.
- `E_A3` in 5 — destination register of the E-stage instruction (0 means none).
- `E_Tnew` in 2 — cycles until the E-stage result is ready (0..2).
- `M_A3` in 5 — destination register of the M-stage instruction.
- `M_Tnew` in 2 — cycles until the M-stage result is ready (0..1).
- `D_md` in 1 — D instruction is MDU-class (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
- `E_start` in 1 — E stage issues mult/multu/div/divu this cycle.
- `E_is_div` in 1 — qualifies `E_start`: 1 = div/divu, 0 = mult/multu.
- `stall` out 1 — combined stall this cycle.
- `F_WE` out 1 — PC write enable; equals `~stall`.
- `D_WE` out 1 — D register write enable; equals `~stall`.
- `E_Flush` out 1 — E register flush (bubble insert); equals `stall`.
- `M_WE`, `W_WE` out 1 — constant 1.
- `M_Flush`, `W_Flush` out 1 — constant 0.
- `md_busy` out 1 — MDU busy, registered.
- `stall_cnt` out 32 — stall cycle counter; present only when `STALL_STAT_EN` is defined.

## Operation

Data stall:
- rs stall: `D_rs != 0`, `D_Tuse_rs != 3`, and either (`D_rs == E_A3` and `D_Tuse_rs < E_Tnew`) or (`D_rs == M_A3` and `D_Tuse_rs < M_Tnew`).
- rt stall: same rule using `D_rt` and `D_Tuse_rt`.
- `data_stall` = rs stall OR rt stall. The comparison is unsigned, 2-bit.

MDU scheduler:
- States: IDLE (`cnt == 0`) and BUSY (`cnt != 0`). `cnt` is a 4-bit register.
- IDLE, `E_start = 1`: load `cnt` with `DIV_CYCLES` if `E_is_div`, otherwise `MULT_CYCLES`; go to BUSY.
- BUSY: decrement `cnt` each cycle; reaching 0 returns to IDLE.
- `E_start` while BUSY reloads `cnt` (restart). Legal code never does this; the rule exists so behaviour is defined.
- `md_busy = (cnt != 0)`.
- `md_stall = D_md & (md_busy | E_start)`.

Combined:
- `stall = data_stall | md_stall`.
- While `reset = 1`: `stall` is forced to 0, so `F_WE = D_WE = 1` and `E_Flush = 0`.

Reset values:
- `cnt = 0`, `md_busy = 0`, `stall_cnt = 0`.
- Combinational outputs take the values given above.

## Timing

- Data stall and all WE/Flush outputs are combinational: same-cycle response, zero latency.
- MDU: if `E_start` is high in cycle t, `md_busy` is high in cycles t+1 .. t+N (N = configured cycles) and low at t+N+1.
- A `D_md` instruction is stalled in cycles t .. t+N and advances at the end of cycle t+N+1.
- Reset asserted mid-BUSY: `cnt` is 0 after the edge, so `md_busy = 0` in the next cycle.

## Configuration

`STALL_STAT_EN`:
- Defined: a 32-bit `stall_cnt` register increments on every cycle with `stall = 1` and `reset = 0`. It saturates at `0xFFFFFFFF` and clears on reset.
- Undefined: the port is absent and no counter logic is built.

## Test plan

- Load-use: `E_A3 = 8`, `E_Tnew = 2`, `D_rs = 8`, `D_Tuse_rs = 1` -> `stall = 1`, `F_WE = D_WE = 0`, `E_Flush = 1`. With `E_Tnew = 1` instead -> `stall = 0`.
- $0 exemption: `D_rs = 0`, `E_A3 = 0`, `E_Tnew = 2`, `D_Tuse_rs = 0` -> `stall = 0`. `D_Tuse_rt = 3` with a matching rt -> no stall.
- Mult: `E_start = 1`, `E_is_div = 0` at cycle 0, `D_md = 1` held -> `stall = 1` in cycles 0..5; `md_busy` high in cycles 1..5; `stall = 0` at cycle 6.
- Div with a non-MDU instruction in D: `E_start = 1`, `E_is_div = 1`, `D_md = 0` -> `stall = 0` throughout; `md_busy` high for exactly 10 cycles.
- Reset mid-div: assert `reset` in cycle 4 after a div issue -> `md_busy = 0` from cycle 5, and a `D_md` instruction is not stalled.
- `STALL_STAT_EN` defined: 7 stall cycles, then `reset` -> `stall_cnt` reads 7 before the reset and 0 after it.
